// File: rtl/dbg_jtag_pkg.sv
// rtl/dbg_jtag_pkg.sv - shared types and constants for the JTAG scan master
package dbg_jtag_pkg;

  typedef enum logic [2:0] {
    TLR_SEQ,
    IDLE,
    IR_HDR,
    SHIFT_IR,
    IR_TO_DR,
    SHIFT_DR,
    DR_TAIL
  } jtag_state_e;

  // tck periods with tms=1 that force the TAP into Test-Logic-Reset
  localparam int TLR_LEN = 5;
  // tms per period, LSB first: SelDR, SelIR, CapIR, ShiftIR (also reused for UpdIR..ShiftDR)
  localparam logic [3:0] IR_HDR_TMS = 4'b0011;
  // tms per period, LSB first: UpdDR, RTI
  localparam logic [1:0] DR_TAIL_TMS = 2'b01;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/dbg_jtag_tck_gen.sv
// rtl/dbg_jtag_tck_gen.sv - tck half-period divider with rise/fall strobes
module dbg_jtag_tck_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en_i,
  output logic tck_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tck_q, tck_d;
  logic          half_end;

  // With CLK_DIV=1 the count never leaves 0, so every clk ends a half period
  assign half_end = (cnt_q == CW'(CLK_DIV - 1));
  assign rise_o   = en_i && half_end && !tck_q;
  assign fall_o   = en_i && half_end && tck_q;
  assign tck_o    = tck_q;

  // Count halves while enabled; park low with a cleared count otherwise
  always_comb begin
    cnt_d = '0;
    tck_d = 1'b0;
    if (en_i) begin
      if (half_end) begin
        cnt_d = '0;
        tck_d = !tck_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
        tck_d = tck_q;
      end
    end
  end

  // Divider state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      tck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tck_q <= tck_d;
    end
  end

endmodule

// File: rtl/dbg_jtag_scan_master.sv
// rtl/dbg_jtag_scan_master.sv - IR+DR JTAG scan initiator; optional IR cache via DBG_JTAG_SCAN_IR_CACHE_EN
module dbg_jtag_scan_master
  import dbg_jtag_pkg::*;
#(
  parameter int IR_W    = 2,
  parameter int DR_W    = 38,
  parameter int CLK_DIV = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [IR_W-1:0] cmd_ir,
  input  logic [DR_W-1:0] cmd_dr,
  output logic            rsp_valid,
  output logic [DR_W-1:0] rsp_dr,
  output logic            busy,
  output logic            tck,
  output logic            tms,
  output logic            tdi,
  input  logic            tdo
);

  localparam int BW = $clog2(max3(IR_W, DR_W, 6) + 1);

  jtag_state_e     state_q, state_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [IR_W-1:0] ir_q, ir_d;
  logic [DR_W-1:0] dr_q, dr_d;
  logic [DR_W-1:0] cap_q, cap_d;
  logic [DR_W-1:0] rsp_dr_q, rsp_dr_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            tms_q, tms_d;
  logic            tdi_q, tdi_d;
  logic            tck_rise, tck_fall;

`ifdef DBG_JTAG_SCAN_IR_CACHE_EN
  logic [IR_W-1:0] cache_ir_q, cache_ir_d;
  logic            cache_vld_q, cache_vld_d;
  logic            cache_hit;
  assign cache_hit = cache_vld_q && (cache_ir_q == cmd_ir);
`endif

  assign busy      = (state_q != IDLE);
  assign cmd_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_dr    = rsp_dr_q;
  assign tms       = tms_q;
  assign tdi       = tdi_q;

  dbg_jtag_tck_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tck_gen (
    .clk    (clk),
    .reset_n(reset_n),
    .en_i   (busy),
    .tck_o  (tck),
    .rise_o (tck_rise),
    .fall_o (tck_fall)
  );

  // Walk the TAP sequence one tck period per falling edge; IR/DR shift right so bit 0 is next
  always_comb begin
    state_d     = state_q;
    bit_d       = bit_q;
    ir_d        = ir_q;
    dr_d        = dr_q;
    cap_d       = cap_q;
    rsp_dr_d    = rsp_dr_q;
    rsp_valid_d = 1'b0;
`ifdef DBG_JTAG_SCAN_IR_CACHE_EN
    cache_ir_d  = cache_ir_q;
    cache_vld_d = cache_vld_q;
`endif
    if (state_q == SHIFT_DR && tck_rise) begin
      cap_d = {tdo, cap_q[DR_W-1:1]};
    end
    case (state_q)
      TLR_SEQ: if (tck_fall) begin
        if (bit_q == BW'(TLR_LEN)) begin
          state_d = IDLE;
          bit_d   = '0;
        end else begin
          bit_d = bit_q + BW'(1);
        end
      end
      IDLE: if (cmd_valid) begin
        ir_d    = cmd_ir;
        dr_d    = cmd_dr;
        state_d = IR_HDR;
        bit_d   = '0;
`ifdef DBG_JTAG_SCAN_IR_CACHE_EN
        if (cache_hit) begin
          // TAP already holds this IR: enter at SelDR of the IR-to-DR walk
          state_d = IR_TO_DR;
          bit_d   = BW'(1);
        end else begin
          cache_ir_d  = cmd_ir;
          cache_vld_d = 1'b1;
        end
`endif
      end
      IR_HDR: if (tck_fall) begin
        if (bit_q == BW'(3)) begin
          state_d = SHIFT_IR;
          bit_d   = '0;
        end else begin
          bit_d = bit_q + BW'(1);
        end
      end
      SHIFT_IR: if (tck_fall) begin
        if (bit_q == BW'(IR_W - 1)) begin
          state_d = IR_TO_DR;
          bit_d   = '0;
        end else begin
          bit_d = bit_q + BW'(1);
          ir_d  = ir_q >> 1;
        end
      end
      IR_TO_DR: if (tck_fall) begin
        if (bit_q == BW'(3)) begin
          state_d = SHIFT_DR;
          bit_d   = '0;
        end else begin
          bit_d = bit_q + BW'(1);
        end
      end
      SHIFT_DR: if (tck_fall) begin
        if (bit_q == BW'(DR_W - 1)) begin
          state_d = DR_TAIL;
          bit_d   = '0;
        end else begin
          bit_d = bit_q + BW'(1);
          dr_d  = dr_q >> 1;
        end
      end
      DR_TAIL: if (tck_fall) begin
        if (bit_q == BW'(1)) begin
          state_d     = IDLE;
          bit_d       = '0;
          rsp_valid_d = 1'b1;
          rsp_dr_d    = cap_q;
        end else begin
          bit_d = bit_q + BW'(1);
        end
      end
      default: begin
        state_d = TLR_SEQ;
        bit_d   = '0;
      end
    endcase
  end

  // Decode tms/tdi for the period about to start, so the pins move with the falling edge
  always_comb begin
    tms_d = 1'b0;
    tdi_d = 1'b0;
    case (state_d)
      TLR_SEQ:            tms_d = (bit_d < BW'(TLR_LEN));
      IR_HDR, IR_TO_DR:   tms_d = IR_HDR_TMS[bit_d[1:0]];
      SHIFT_IR: begin
        tms_d = (bit_d == BW'(IR_W - 1));
        tdi_d = ir_d[0];
      end
      SHIFT_DR: begin
        tms_d = (bit_d == BW'(DR_W - 1));
        tdi_d = dr_d[0];
      end
      DR_TAIL:            tms_d = DR_TAIL_TMS[bit_d[0]];
      default:            tms_d = 1'b0;
    endcase
  end

  // Scan state register; reset drives the TAP toward Test-Logic-Reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= TLR_SEQ;
      bit_q       <= '0;
      ir_q        <= '0;
      dr_q        <= '0;
      cap_q       <= '0;
      rsp_dr_q    <= '0;
      rsp_valid_q <= 1'b0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_q       <= bit_d;
      ir_q        <= ir_d;
      dr_q        <= dr_d;
      cap_q       <= cap_d;
      rsp_dr_q    <= rsp_dr_d;
      rsp_valid_q <= rsp_valid_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
    end
  end

`ifdef DBG_JTAG_SCAN_IR_CACHE_EN
  // Last-shifted IR, invalid until the first full scan after reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cache_ir_q  <= '0;
      cache_vld_q <= 1'b0;
    end else begin
      cache_ir_q  <= cache_ir_d;
      cache_vld_q <= cache_vld_d;
    end
  end
`endif

endmodule
